// File: rtl/vend_seq_core_if.sv
// Instruction ROM bus between the sequencer (master) and the ROM (slave).
// Latency: none. The ROM answers combinationally from rom_addr.
// Backpressure: none. The sequencer owns the pacing of fetches.
interface vend_seq_core_if #(
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] rom_addr;
  logic [18:0]       rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/vend_seq_core.sv
// Fetch/execute sequencer running vending ROM programs against a 16-entry register file.
// Latency: 2 cycles per instruction; done pulses 3+2*end_addr cycles after the start edge.
// Backpressure: none; start/clr are ignored while busy, and clr wins over start in IDLE.
module vend_seq_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   end_addr,
  input  logic                clr,
  vend_seq_core_if.master     rom,
  output logic                busy,
  output logic                done,
  output logic                carry,
  input  logic [3:0]          dbg_sel,
  output logic [DATA_W-1:0]   dbg_data
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_rom_addr;
  logic [ADDR_W-1:0]   r_end_addr;
  logic [18:0]         r_ir;
  logic [DATA_W-1:0]   r_regs [16];
  logic                r_carry;

  // Decoded instruction fields.
  logic [2:0]          w_op;
  logic [3:0]          w_rd;
  logic [3:0]          w_rs;
  logic [3:0]          w_rt;
  logic [DATA_W-1:0]   w_imm;
  logic [DATA_W-1:0]   w_rs_val;
  logic [DATA_W-1:0]   w_rt_val;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W:0]     w_diff;
  logic [DATA_W-1:0]   w_res;
  logic                w_we;
  logic                w_carry_set;
  logic                w_is_last;
  logic                w_launch;

  assign w_op     = r_ir[18:16];
  assign w_rd     = r_ir[15:12];
  assign w_rs     = r_ir[11:8];
  assign w_rt     = r_ir[7:4];
  assign w_imm    = r_ir[DATA_W-1:0];
  // r0 is never written, so reading it straight from the array yields 0.
  assign w_rs_val = r_regs[w_rs];
  assign w_rt_val = r_regs[w_rt];

  assign w_is_last = (r_rom_addr == r_end_addr);
  assign w_launch  = (r_state == ST_IDLE) && !clr && start;

  assign rom.rom_addr = r_rom_addr;
  assign busy         = (r_state != ST_IDLE);
  assign done         = (r_state == ST_DONE);
  assign carry        = r_carry;
  assign dbg_data     = (dbg_sel == 4'd0) ? '0 : r_regs[dbg_sel];

  // ALU: compute the result, write enable and sticky-flag contribution of the held instruction.
  always_comb begin
    w_res       = '0;
    w_we        = 1'b0;
    w_carry_set = 1'b0;
    w_sum       = {1'b0, w_rs_val} + {1'b0, w_rt_val};
    w_diff      = {1'b0, w_rs_val} - {1'b0, w_rt_val};
    case (w_op)
      3'd0: begin
        w_res       = w_sum[DATA_W-1:0];
        w_we        = 1'b1;
        w_carry_set = w_sum[DATA_W];
      end
      3'd1: begin
        w_res       = w_diff[DATA_W-1:0];
        w_we        = 1'b1;
        w_carry_set = w_diff[DATA_W];
      end
      3'd2: begin
        w_res = w_rs_val & w_rt_val;
        w_we  = 1'b1;
      end
      3'd3: begin
        w_res = w_rs_val | w_rt_val;
        w_we  = 1'b1;
      end
      3'd4: begin
        w_res = {{(DATA_W-1){1'b0}}, (w_rs_val < w_rt_val)};
        w_we  = 1'b1;
      end
      3'd7: begin
        w_res = w_imm;
        w_we  = 1'b1;
      end
      default: begin
        w_res = '0;
        w_we  = 1'b0;
      end
    endcase
  end

  // Next-state logic for the fetch/execute loop.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_launch) w_state_nxt = ST_FETCH;
      ST_FETCH: w_state_nxt = ST_EXEC;
      ST_EXEC:  w_state_nxt = w_is_last ? ST_DONE : ST_FETCH;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Program counter, end-address latch and instruction register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_addr <= '0;
      r_end_addr <= '0;
      r_ir       <= '0;
    end else begin
      if (w_launch) begin
        r_end_addr <= end_addr;
        r_rom_addr <= '0;
      end
      if (r_state == ST_FETCH) begin
        r_ir <= rom.rom_data;
      end
      // Stop advancing at the last instruction so rom_addr never wraps.
      if (r_state == ST_EXEC && !w_is_last) begin
        r_rom_addr <= r_rom_addr + 1'b1;
      end
    end
  end

  // Register file and sticky carry: clear in IDLE, write back at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        r_regs[i] <= '0;
      end
      r_carry <= 1'b0;
    end else if (r_state == ST_IDLE && clr) begin
      for (int i = 0; i < 16; i++) begin
        r_regs[i] <= '0;
      end
      r_carry <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      if (w_we && w_rd != 4'd0) begin
        r_regs[w_rd] <= w_res;
      end
      if (w_carry_set) begin
        r_carry <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vend_seq_core.sv
// Testbench for vend_seq_core: directed programs from the test plan plus randomized programs.
// Expected register/carry state comes from an instruction-level model applied per run.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_vend_seq_core;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] end_addr;
  logic       clr;
  logic       busy;
  logic       done;
  logic       carry;
  logic [3:0] dbg_sel;
  logic [7:0] dbg_data;

  int checks;
  int failures;

  vend_seq_core_if #(.ADDR_W(3)) rom_if ();

  logic [18:0] rom_mem [8];
  assign rom_if.rom_data = rom_mem[rom_if.rom_addr];

  vend_seq_core #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .end_addr (end_addr),
    .clr      (clr),
    .rom      (rom_if.master),
    .busy     (busy),
    .done     (done),
    .carry    (carry),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  logic [7:0] m_regs [16];
  logic       m_carry;

  // Run observations.
  int         done_cycle;
  int         done_cnt;
  logic [2:0] addr_log [$];

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'd0;
    m_carry = 1'b0;
  endtask

  // Execute instructions 0..end_a of rom_mem on the model, one instruction at a time.
  task automatic model_run(input int end_a);
    for (int k = 0; k <= end_a; k++) begin
      int op, rd, a, b, r;
      bit wr;
      op = int'(rom_mem[k][18:16]);
      rd = int'(rom_mem[k][15:12]);
      a  = int'(m_regs[rom_mem[k][11:8]]);
      b  = int'(m_regs[rom_mem[k][7:4]]);
      wr = 1'b1;
      r  = 0;
      case (op)
        0: begin r = a + b; if (r > 255) m_carry = 1'b1; r = r % 256; end
        1: begin if (a < b) m_carry = 1'b1; r = (a - b + 256) % 256; end
        2: r = a & b;
        3: r = a | b;
        4: r = (a < b) ? 1 : 0;
        7: r = int'(rom_mem[k][11:0]) % 256;
        default: wr = 1'b0;
      endcase
      if (wr && rd != 0) m_regs[rd] = 8'(r);
    end
  endtask

  // Launch one run from IDLE; optionally keep hammering start/clr while busy.
  task automatic run_prog(input int end_a, input bit hold);
    addr_log.delete();
    done_cycle = -1;
    done_cnt   = 0;
    @(negedge clk);
    end_addr = 3'(end_a);
    start    = 1'b1;
    for (int n = 1; n <= 2 * end_a + 8; n++) begin
      @(negedge clk);
      if (busy) addr_log.push_back(rom_if.rom_addr);
      if (done) begin
        done_cnt++;
        if (done_cycle < 0) done_cycle = n;
      end
      start    = hold & busy;
      clr      = hold & busy;
      end_addr = 3'($urandom_range(0, 7));
    end
    start = 1'b0;
    clr   = 1'b0;
    model_run(end_a);
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || carry !== 1'b0 || rom_if.rom_addr !== 3'd0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b done=%b carry=%b rom_addr=%0d, want all 0",
               busy, done, carry, rom_if.rom_addr);
    end
    for (int i = 0; i < 16; i++) begin
      dbg_sel = 4'(i); #1;
      checks++;
      if (dbg_data !== 8'd0) begin
        failures++;
        $display("FAIL reset_reg r%0d: got %0d want 0", i, dbg_data);
      end
    end
  endtask

  task automatic load_tens();
    for (int i = 0; i < 8; i++) rom_mem[i] = 19'h7f000;
    rom_mem[1] = 19'h7100a;
    rom_mem[2] = 19'h04140;
  endtask

  task automatic test_basic_program();
    logic [2:0] exp_log [$];
    load_tens();
    run_prog(3, 1'b0);
    checks++;
    if (done_cycle !== 9 || done_cnt !== 1) begin
      failures++;
      $display("FAIL basic_done: cycle=%0d pulses=%0d want cycle 9, 1 pulse", done_cycle, done_cnt);
    end
    for (int k = 0; k <= 3; k++) begin exp_log.push_back(3'(k)); exp_log.push_back(3'(k)); end
    exp_log.push_back(3'd3);
    checks++;
    if (addr_log != exp_log) begin
      failures++;
      $display("FAIL basic_rom_addr_seq: got %p want %p", addr_log, exp_log);
    end
    dbg_sel = 4'd1; #1; checks++;
    if (dbg_data !== 8'd10) begin failures++; $display("FAIL basic_r1: got %0d want 10", dbg_data); end
    dbg_sel = 4'd4; #1; checks++;
    if (dbg_data !== 8'd10) begin failures++; $display("FAIL basic_r4: got %0d want 10", dbg_data); end
    dbg_sel = 4'd15; #1; checks++;
    if (dbg_data !== 8'd0) begin failures++; $display("FAIL basic_r15: got %0d want 0", dbg_data); end
    checks++;
    if (carry !== 1'b0) begin failures++; $display("FAIL basic_carry: got %b want 0", carry); end
  endtask

  task automatic test_accumulate_clr();
    run_prog(3, 1'b0);
    dbg_sel = 4'd4; #1; checks++;
    if (dbg_data !== 8'd20) begin failures++; $display("FAIL accum_r4: got %0d want 20", dbg_data); end
    // clr together with start: clr wins and no run begins.
    @(negedge clk);
    clr = 1'b1; start = 1'b1;
    @(negedge clk);
    clr = 1'b0; start = 1'b0;
    model_clear();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL clr_priority_busy: got %b want 0", busy); end
    dbg_sel = 4'd4; #1; checks++;
    if (dbg_data !== 8'd0) begin failures++; $display("FAIL clr_r4: got %0d want 0", dbg_data); end
    run_prog(3, 1'b0);
    dbg_sel = 4'd4; #1; checks++;
    if (dbg_data !== 8'd10) begin failures++; $display("FAIL after_clr_r4: got %0d want 10", dbg_data); end
  endtask

  task automatic test_wrap_carry();
    rom_mem[0] = 19'h740fa;
    run_prog(0, 1'b0);
    load_tens();
    run_prog(3, 1'b0);
    dbg_sel = 4'd4; #1; checks++;
    if (dbg_data !== 8'd4) begin failures++; $display("FAIL wrap_r4: got %0d want 4", dbg_data); end
    checks++;
    if (carry !== 1'b1) begin failures++; $display("FAIL wrap_carry: got %b want 1", carry); end
    run_prog(0, 1'b0);
    checks++;
    if (carry !== 1'b1 || done_cycle !== 3) begin
      failures++;
      $display("FAIL sticky_carry: carry=%b done_cycle=%0d want 1 and 3", carry, done_cycle);
    end
  endtask

  task automatic test_r0_write();
    do_clr();
    rom_mem[0] = 19'h7000f;
    rom_mem[1] = 19'h01100;
    run_prog(1, 1'b0);
    dbg_sel = 4'd0; #1; checks++;
    if (dbg_data !== 8'd0) begin failures++; $display("FAIL r0_reads_zero: got %0d want 0", dbg_data); end
    dbg_sel = 4'd1; #1; checks++;
    if (dbg_data !== 8'd0 || carry !== 1'b0) begin
      failures++;
      $display("FAIL r0_sub: r1=%0d carry=%b want 0 and 0", dbg_data, carry);
    end
  endtask

  task automatic test_start_while_busy();
    load_tens();
    run_prog(3, 1'b1);
    checks++;
    if (done_cnt !== 1 || done_cycle !== 9) begin
      failures++;
      $display("FAIL busy_start: pulses=%0d cycle=%0d want 1 pulse at 9", done_cnt, done_cycle);
    end
    for (int i = 0; i < 16; i++) begin
      dbg_sel = 4'(i); #1; checks++;
      if (dbg_data !== m_regs[i]) begin
        failures++;
        $display("FAIL busy_clr_ignored r%0d: got %0d want %0d", i, dbg_data, m_regs[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      int ea;
      if ($urandom_range(0, 3) == 0) do_clr();
      for (int k = 0; k < 8; k++) rom_mem[k] = 19'($urandom);
      ea = int'($urandom_range(0, 7));
      run_prog(ea, 1'($urandom_range(0, 1)));
      checks++;
      if (done_cycle !== 3 + 2 * ea || done_cnt !== 1) begin
        failures++;
        $display("FAIL rand_done it%0d: cycle=%0d pulses=%0d want %0d, 1", it, done_cycle, done_cnt, 3 + 2 * ea);
      end
      for (int i = 0; i < 16; i++) begin
        dbg_sel = 4'(i); #1; checks++;
        if (dbg_data !== m_regs[i]) begin
          failures++;
          $display("FAIL rand_reg it%0d r%0d: got %0d want %0d", it, i, dbg_data, m_regs[i]);
        end
      end
      checks++;
      if (carry !== m_carry) begin
        failures++;
        $display("FAIL rand_carry it%0d: got %b want %b", it, carry, m_carry);
      end
    end
  endtask

  task automatic test_abort();
    int bad;
    // Leave carry and registers nonzero so the reset clear is visible.
    rom_mem[0] = 19'h740ff;
    rom_mem[1] = 19'h04440;
    run_prog(1, 1'b0);
    load_tens();
    @(negedge clk);
    end_addr = 3'd3; start = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (busy !== 1'b1 || rom_if.rom_addr !== 3'd1) begin
      failures++;
      $display("FAIL abort_setup: busy=%b rom_addr=%0d want 1 and 1", busy, rom_if.rom_addr);
    end
    rst_n = 1'b0; #1;
    model_clear();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || carry !== 1'b0 || rom_if.rom_addr !== 3'd0) begin
      failures++;
      $display("FAIL abort_outputs: busy=%b done=%b carry=%b rom_addr=%0d want all 0",
               busy, done, carry, rom_if.rom_addr);
    end
    for (int i = 0; i < 16; i++) begin
      dbg_sel = 4'(i); #1; checks++;
      if (dbg_data !== 8'd0) begin failures++; $display("FAIL abort_reg r%0d: got %0d want 0", i, dbg_data); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL abort_idle: %0d busy/done cycles want 0", bad); end
    run_prog(3, 1'b0);
    dbg_sel = 4'd4; #1; checks++;
    if (dbg_data !== 8'd10 || done_cycle !== 9) begin
      failures++;
      $display("FAIL abort_rerun: r4=%0d cycle=%0d want 10 and 9", dbg_data, done_cycle);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    clr      = 1'b0;
    end_addr = 3'd0;
    dbg_sel  = 4'd0;
    for (int i = 0; i < 8; i++) rom_mem[i] = 19'h7f000;
    model_clear();
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_basic_program();
    test_accumulate_clr();
    test_wrap_carry();
    test_r0_write();
    test_start_while_busy();
    test_random();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
